// File: rtl/hdlverifier_capture_trigger_sequencer.sv
// Capture sequencer: combines comparator triggers and drives circular capture-RAM writes around the trigger.
// Optional WAIT_TRIG timeout enabled by defining HDLV_CAPTURE_TRIG_TIMEOUT_EN.
module hdlverifier_capture_trigger_sequencer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_TRIG   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_enable,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [NUM_TRIG-1:0]   trigger_in,
    input  logic [NUM_TRIG-1:0]   trigger_enable_mask,
    input  logic                  trigger_combine_op,
    input  logic [ADDR_WIDTH-1:0] trigger_position,
`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
    input  logic [31:0]           timeout_cycles,
    output logic                  timed_out,
`endif
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic                  capture_done,
    output logic                  busy,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pos_q;
    logic [ADDR_WIDTH-1:0]   remaining_q;
    logic [ADDR_WIDTH-1:0]   post_len_c;
    logic                    trig_comb_c;
    logic                    trig_fire_c;
    logic                    timeout_hit_c;

    // Live trigger combine: an empty mask means "trigger immediately".
    always_comb begin
        trig_comb_c = 1'b0;
        if (trigger_enable_mask == '0) begin
            trig_comb_c = 1'b1;
        end else if (trigger_combine_op) begin
            trig_comb_c = |(trigger_in & trigger_enable_mask);
        end else begin
            trig_comb_c = &(trigger_in | ~trigger_enable_mask);
        end
    end

`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
    logic [31:0] wait_cnt_q;

    // The write that brings the WAIT_TRIG count up to timeout_cycles is forced as the trigger.
    always_comb begin
        timeout_hit_c = 1'b0;
        if (timeout_cycles != 32'd0) begin
            timeout_hit_c = ((wait_cnt_q + 32'd1) == timeout_cycles);
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    assign trig_fire_c = trig_comb_c | timeout_hit_c;

    // Samples after the trigger: D-1-P, which is the bitwise complement of P.
    assign post_len_c = ~pos_q;

    assign state     = state_q;
    assign busy      = (state_q == ST_PREFILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    assign buf_wr_en = clk_enable & busy;

    // Position is ADDR_WIDTH wide, so it can never exceed D-1 and needs no further clamping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            remaining_q  <= '0;
            buf_wr_addr  <= '0;
            trigger_addr <= '0;
            capture_done <= 1'b0;
`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timed_out    <= 1'b0;
`endif
        end else if (clk_enable) begin
            if (abort) begin
                state_q      <= ST_IDLE;
                capture_done <= 1'b0;
`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
                timed_out    <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            buf_wr_addr  <= '0;
                            capture_done <= 1'b0;
                            pos_q        <= trigger_position;
                            remaining_q  <= trigger_position;
`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
                            wait_cnt_q   <= '0;
                            timed_out    <= 1'b0;
`endif
                            state_q      <= (trigger_position != '0) ? ST_PREFILL : ST_WAIT_TRIG;
                        end
                    end
                    ST_PREFILL: begin
                        buf_wr_addr <= buf_wr_addr + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - ADDR_WIDTH'(1);
                        if (remaining_q == ADDR_WIDTH'(1)) begin
                            state_q <= ST_WAIT_TRIG;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        buf_wr_addr <= buf_wr_addr + ADDR_WIDTH'(1);
`ifdef HDLV_CAPTURE_TRIG_TIMEOUT_EN
                        wait_cnt_q  <= wait_cnt_q + 32'd1;
                        if (timeout_hit_c) begin
                            timed_out <= 1'b1;
                        end
`endif
                        if (trig_fire_c) begin
                            trigger_addr <= buf_wr_addr;
                            remaining_q  <= post_len_c;
                            if (post_len_c == '0) begin
                                state_q      <= ST_DONE;
                                capture_done <= 1'b1;
                            end else begin
                                state_q <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        buf_wr_addr <= buf_wr_addr + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - ADDR_WIDTH'(1);
                        if (remaining_q == ADDR_WIDTH'(1)) begin
                            state_q      <= ST_DONE;
                            capture_done <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdlverifier_capture_trigger_sequencer.sv
// Self-checking bench for the capture trigger sequencer (ADDR_WIDTH=4, D=16, NUM_TRIG=4).
module tb_hdlverifier_capture_trigger_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned NT = 4;
    localparam int          D  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_enable;
    logic          arm;
    logic          abort;
    logic [NT-1:0] trigger_in;
    logic [NT-1:0] trigger_enable_mask;
    logic          trigger_combine_op;
    logic [AW-1:0] trigger_position;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [AW-1:0] trigger_addr;
    logic          capture_done;
    logic          busy;
    logic [2:0]    state;

    int checks = 0;
    int passes = 0;
    int prev_ta = 0;
    int obs_done_cyc;
    logic [NT-1:0] tq [0:127];

    hdlverifier_capture_trigger_sequencer #(.ADDR_WIDTH(AW), .NUM_TRIG(NT)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .clk_enable          (clk_enable),
        .arm                 (arm),
        .abort               (abort),
        .trigger_in          (trigger_in),
        .trigger_enable_mask (trigger_enable_mask),
        .trigger_combine_op  (trigger_combine_op),
        .trigger_position    (trigger_position),
        .buf_wr_en           (buf_wr_en),
        .buf_wr_addr         (buf_wr_addr),
        .trigger_addr        (trigger_addr),
        .capture_done        (capture_done),
        .busy                (busy),
        .state               (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        else passes++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference trigger decision computed by counting enabled and asserted inputs.
    function automatic logic comb_trig(input logic [NT-1:0] t, input logic [NT-1:0] m, input logic o);
        int en_cnt = 0;
        int hit_cnt = 0;
        for (int i = 0; i < NT; i++) begin
            if (m[i]) begin
                en_cnt++;
                if (t[i]) hit_cnt++;
            end
        end
        if (en_cnt == 0) return 1'b1;
        return o ? (hit_cnt > 0) : (hit_cnt == en_cnt);
    endfunction

    task automatic clear_tq(input logic [NT-1:0] v);
        for (int i = 0; i < 128; i++) tq[i] = v;
    endtask

    task automatic do_abort();
        tick();
        abort = 1'b1;
        trigger_in = '0;
        tick();
        abort = 1'b0;
        #1;
        check_eq("abort_state", int'(state), 0);
        check_eq("abort_done", int'(capture_done), 0);
        check_eq("abort_wr_en", int'(buf_wr_en), 0);
    endtask

    // Arm at cycle 0 with position p, then play tq[1..n]; expectations come from write-count arithmetic.
    task automatic run_capture(input int p, input logic [NT-1:0] m, input logic o, input int n);
        int tc;
        int dc;
        int es;
        int ea;
        int eta;
        tc = -1;
        for (int c = p + 1; c <= n; c++) begin
            if (tc < 0 && comb_trig(tq[c], m, o)) tc = c;
        end
        dc = (tc < 0) ? 1 << 30 : tc + D - p;
        obs_done_cyc = -1;
        tick();
        arm = 1'b1;
        trigger_position = AW'(p);
        trigger_enable_mask = m;
        trigger_combine_op = o;
        trigger_in = tq[0];
        for (int c = 1; c <= n; c++) begin
            tick();
            arm = 1'b0;
            trigger_in = tq[c];
            #1;
            if (c >= dc) es = 4;
            else if (c <= p) es = 1;
            else if (tc < 0 || c <= tc) es = 2;
            else es = 3;
            ea  = (es == 4) ? (dc - 1) % D : (c - 1) % D;
            eta = (tc >= 0 && c > tc) ? (tc - 1) % D : prev_ta;
            check_eq("state", int'(state), es);
            check_eq("wr_addr", int'(buf_wr_addr), ea);
            check_eq("wr_en", int'(buf_wr_en), (es != 4) ? 1 : 0);
            check_eq("busy", int'(busy), (es != 4) ? 1 : 0);
            check_eq("done", int'(capture_done), (es == 4) ? 1 : 0);
            check_eq("trig_addr", int'(trigger_addr), eta);
            if (obs_done_cyc < 0 && capture_done === 1'b1) obs_done_cyc = c;
        end
        if (tc >= 0) prev_ta = (tc - 1) % D;
        if (dc > n) do_abort();
    endtask

    initial begin
        reset_n = 1'b0;
        clk_enable = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        trigger_in = '0;
        trigger_enable_mask = '0;
        trigger_combine_op = 1'b0;
        trigger_position = '0;
        #12;
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_wr_en", int'(buf_wr_en), 0);
        check_eq("rst_addr", int'(buf_wr_addr), 0);
        check_eq("rst_taddr", int'(trigger_addr), 0);
        check_eq("rst_done", int'(capture_done), 0);
        check_eq("rst_busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;

        // Basic capture: single trigger pulse on input 0 at cycle 9.
        clear_tq('0);
        tq[9] = 4'b0001;
        run_capture(4, 4'b0001, 1'b1, 24);
        check_eq("basic_done_cyc", obs_done_cyc, 21);
        check_eq("basic_taddr", int'(trigger_addr), 8);

        // Trigger present only during prefill must be ignored.
        clear_tq('0);
        for (int c = 1; c <= 4; c++) tq[c] = 4'b0001;
        run_capture(4, 4'b0001, 1'b1, 20);

        // AND of mask 0110: partial match does not trigger, full match does.
        clear_tq('0);
        for (int c = 1; c <= 7; c++) tq[c] = 4'b0100;
        tq[8] = 4'b0110;
        run_capture(2, 4'b0110, 1'b0, 30);
        check_eq("and_taddr", int'(trigger_addr), 7);

        // Empty mask triggers on the first WAIT_TRIG write.
        clear_tq('0);
        run_capture(3, 4'b0000, 1'b0, 24);
        check_eq("mask0_taddr", int'(trigger_addr), 3);

        // P=0 with trigger held high.
        clear_tq(4'b1111);
        run_capture(0, 4'b0001, 1'b1, 20);
        check_eq("p0_done_cyc", obs_done_cyc, 17);
        check_eq("p0_taddr", int'(trigger_addr), 0);

        // Maximum position: trigger is the 16th write, no POST phase.
        clear_tq('0);
        run_capture(15, 4'b0000, 1'b0, 20);
        check_eq("pmax_done_cyc", obs_done_cyc, 17);
        check_eq("pmax_taddr", int'(trigger_addr), 15);

        // Abort during POST.
        tick();
        arm = 1'b1;
        trigger_position = AW'(2);
        trigger_enable_mask = '0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            arm = 1'b0;
        end
        check_eq("pre_abort_state", int'(state), 3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_eq("post_abort_state", int'(state), 0);
        check_eq("post_abort_wr_en", int'(buf_wr_en), 0);
        check_eq("post_abort_done", int'(capture_done), 0);
        check_eq("post_abort_taddr", int'(trigger_addr), 2);
        prev_ta = 2;

        // arm and abort together from IDLE.
        tick();
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        #1;
        check_eq("arm_abort_state", int'(state), 0);
        check_eq("arm_abort_busy", int'(busy), 0);

        // clk_enable low for cycles 8..10 inside POST delays done by three cycles.
        tick();
        arm = 1'b1;
        trigger_position = AW'(4);
        trigger_enable_mask = '0;
        obs_done_cyc = -1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            arm = 1'b0;
            clk_enable = (c >= 8 && c <= 10) ? 1'b0 : 1'b1;
            #1;
            if (c >= 8 && c <= 10) begin
                check_eq("gap_wr_en", int'(buf_wr_en), 0);
                check_eq("gap_addr", int'(buf_wr_addr), 7);
            end
            if (obs_done_cyc < 0 && capture_done === 1'b1) obs_done_cyc = c;
        end
        clk_enable = 1'b1;
        check_eq("gap_done_cyc", obs_done_cyc, 20);
        prev_ta = 4;

        // Randomized captures against the reference model.
        for (int k = 0; k < 16; k++) begin
            int p;
            logic [NT-1:0] m;
            logic o;
            p = int'($urandom_range(0, 15));
            m = NT'($urandom_range(0, 15));
            o = 1'($urandom_range(0, 1));
            for (int c = 0; c < 128; c++) tq[c] = NT'($urandom_range(0, 15));
            run_capture(p, m, o, p + 36);
        end

        // Asynchronous reset mid-capture.
        tick();
        arm = 1'b1;
        trigger_position = AW'(5);
        for (int c = 1; c <= 3; c++) begin
            tick();
            arm = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_eq("midrst_state", int'(state), 0);
        check_eq("midrst_addr", int'(buf_wr_addr), 0);
        check_eq("midrst_taddr", int'(trigger_addr), 0);
        check_eq("midrst_wr_en", int'(buf_wr_en), 0);
        tick();
        reset_n = 1'b1;
        prev_ta = 0;

        // Capture after reset still works.
        clear_tq('0);
        tq[12] = 4'b1000;
        run_capture(6, 4'b1001, 1'b1, 30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
